// File: rtl/wb_port_arbiter.sv
// Purpose: shares the register-file write port between the WB stage and buffered custom-IP results.
// Latency: pipeline writes reach the port in the same cycle; IP results reach it one or more cycles after acceptance.
// Backpressure: ip_ready drops while the FIFO is full; wb_stall_req asks for a bubble when the FIFO head starves.
module wb_port_arbiter #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RegWrite_WB,
   input  logic [4:0]  Rd_WB,
   input  logic [31:0] Result_WB,
   input  logic        ip_valid,
   input  logic [4:0]  ip_rd,
   input  logic [31:0] ip_data,
   output logic        ip_ready,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic [31:0] pending_mask,
   output logic        wb_stall_req
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int NW = $clog2(DEPTH + 1);
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [NW-1:0] FULL_CNT   = NW'(DEPTH);
   localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] dat;
   } ent_t;

   // FIFO storage; a slot's live bit is the only thing that makes its contents meaningful
   ent_t             mem_q [DEPTH];
   logic [DEPTH-1:0] live_q;
   logic [DEPTH-1:0] live_nxt;
   logic [AW-1:0]    rptr_q;
   logic [AW-1:0]    wptr_q;
   logic [NW-1:0]    cnt_q;
   logic [NW-1:0]    cnt_nxt;
   logic [CW-1:0]    starve_q;
   logic [CW-1:0]    starve_nxt;
   logic             stall_q;
   logic [31:0]      mask_q;
   logic [31:0]      mask_nxt;
   logic [4:0]       slot_rd;

   logic             pwr;
   logic             full;
   logic             not_empty;
   logic             head_live;
   logic             push;
   logic             pop;
   logic             head_kill;
   logic             blocked;
   ent_t             head;

   // Handshake and head status: the pipeline owns the port, r0 writes never happen,
   // and a dead head leaves the FIFO whether or not the port is busy.
   always_comb begin
      pwr       = RegWrite_WB && (Rd_WB != 5'd0);
      full      = (cnt_q == FULL_CNT);
      not_empty = (cnt_q != '0);
      head      = mem_q[rptr_q];
      head_live = live_q[rptr_q];
      push      = ip_valid && !full && (ip_rd != 5'd0);
      pop       = not_empty && (!head_live || !pwr);
      head_kill = pwr && head_live && (head.rd == Rd_WB);
      blocked   = pwr && head_live && !head_kill;
   end

   assign ip_ready     = !full;
   assign pending_mask = mask_q;
   assign wb_stall_req = stall_q;

   // Write-port mux: pipeline first, then a live FIFO head, otherwise idle zeros
   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = 5'd0;
      rf_wdata = 32'd0;
      if (pwr) begin
         rf_we    = 1'b1;
         rf_waddr = Rd_WB;
         rf_wdata = Result_WB;
      end else if (head_live) begin
         rf_we    = 1'b1;
         rf_waddr = head.rd;
         rf_wdata = head.dat;
      end
   end

   // Next liveness: a younger pipeline write kills matching entries (including one
   // accepted this very cycle); the mask is decoded from the post-edge liveness.
   always_comb begin
      live_nxt = live_q;
      mask_nxt = 32'd0;
      slot_rd  = 5'd0;
      for (int i = 0; i < DEPTH; i++) begin
         if (pwr && live_q[i] && (mem_q[i].rd == Rd_WB)) begin
            live_nxt[i] = 1'b0;
         end
      end
      if (pop) begin
         live_nxt[rptr_q] = 1'b0;
      end
      if (push) begin
         live_nxt[wptr_q] = !(pwr && (ip_rd == Rd_WB));
      end
      for (int i = 0; i < DEPTH; i++) begin
         slot_rd = (push && (wptr_q == AW'(i))) ? ip_rd : mem_q[i].rd;
         if (live_nxt[i]) begin
            mask_nxt[slot_rd] = 1'b1;
         end
      end
      mask_nxt[0] = 1'b0;
   end

   // Occupancy and starvation bookkeeping; the counter only survives while the same
   // live head keeps losing the port, and saturates at the limit.
   always_comb begin
      cnt_nxt = cnt_q;
      case ({push, pop})
         2'b10:   cnt_nxt = cnt_q + NW'(1);
         2'b01:   cnt_nxt = cnt_q - NW'(1);
         default: cnt_nxt = cnt_q;
      endcase
      starve_nxt = '0;
      if (blocked) begin
         starve_nxt = (starve_q == STARVE_MAX) ? starve_q : starve_q + CW'(1);
      end
   end

   // Control state; reset discards every buffered result immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         live_q   <= '0;
         rptr_q   <= '0;
         wptr_q   <= '0;
         cnt_q    <= '0;
         starve_q <= '0;
         stall_q  <= 1'b0;
         mask_q   <= 32'd0;
      end else begin
         live_q   <= live_nxt;
         cnt_q    <= cnt_nxt;
         starve_q <= starve_nxt;
         stall_q  <= (starve_nxt == STARVE_MAX);
         mask_q   <= mask_nxt;
         if (push) begin
            wptr_q <= wptr_q + AW'(1);
         end
         if (pop) begin
            rptr_q <= rptr_q + AW'(1);
         end
      end
   end

   // Payload storage needs no reset: nothing reads a slot unless its live bit is set
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q] <= '{rd: ip_rd, dat: ip_data};
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Purpose: self-checking bench for wb_port_arbiter against a queue-based reference model.
// Latency: one step task per clock; outputs sampled on the falling edge.
// Backpressure: the model accepts an IP result only when it holds fewer than DEPTH entries.
module tb_wb_port_arbiter;

   localparam int DEPTH = 4;
   localparam int LIM   = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        RegWrite_WB;
   logic [4:0]  Rd_WB;
   logic [31:0] Result_WB;
   logic        ip_valid;
   logic [4:0]  ip_rd;
   logic [31:0] ip_data;
   logic        ip_ready;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [31:0] pending_mask;
   logic        wb_stall_req;

   wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .RegWrite_WB  (RegWrite_WB),
      .Rd_WB        (Rd_WB),
      .Result_WB    (Result_WB),
      .ip_valid     (ip_valid),
      .ip_rd        (ip_rd),
      .ip_data      (ip_data),
      .ip_ready     (ip_ready),
      .rf_we        (rf_we),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .pending_mask (pending_mask),
      .wb_stall_req (wb_stall_req)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] dat;
      bit          live;
   } ment_t;

   ment_t mq[$];
   int    m_blocked;
   bit    m_stall;
   int    nchk  = 0;
   int    npass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      assert (got === exp) npass++;
      else $error("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   function automatic logic [31:0] m_mask();
      logic [31:0] m;
      m = 32'd0;
      foreach (mq[i]) begin
         if (mq[i].live && mq[i].rd != 5'd0) m[mq[i].rd] = 1'b1;
      end
      return m;
   endfunction

   // One clock: drive inputs, check every output against the model, then advance the model at the edge
   task automatic step(input bit rw, input logic [4:0] rd, input logic [31:0] res,
                       input bit iv, input logic [4:0] ird, input logic [31:0] idat);
      bit          pwr, rdy, hl, kill_head, blk, pop;
      logic        e_we;
      logic [4:0]  e_wa;
      logic [31:0] e_wd;
      #1;
      RegWrite_WB = rw;
      Rd_WB       = rd;
      Result_WB   = res;
      ip_valid    = iv;
      ip_rd       = ird;
      ip_data     = idat;
      pwr = rw && (rd != 5'd0);
      rdy = (mq.size() < DEPTH);
      hl  = (mq.size() > 0) && mq[0].live;
      if (pwr) begin
         e_we = 1'b1; e_wa = rd; e_wd = res;
      end else if (hl) begin
         e_we = 1'b1; e_wa = mq[0].rd; e_wd = mq[0].dat;
      end else begin
         e_we = 1'b0; e_wa = 5'd0; e_wd = 32'd0;
      end
      @(negedge clk);
      chk("rf_we",        32'(rf_we),        32'(e_we));
      chk("rf_waddr",     32'(rf_waddr),     32'(e_wa));
      chk("rf_wdata",     rf_wdata,          e_wd);
      chk("ip_ready",     32'(ip_ready),     32'(rdy));
      chk("pending_mask", pending_mask,      m_mask());
      chk("wb_stall_req", 32'(wb_stall_req), 32'(m_stall));
      @(posedge clk);
      kill_head = pwr && hl && (mq[0].rd == rd);
      blk       = pwr && hl && !kill_head;
      pop       = (mq.size() > 0) && (!mq[0].live || !pwr);
      if (pwr) begin
         foreach (mq[i]) if (mq[i].rd == rd) mq[i].live = 1'b0;
      end
      if (pop) mq.delete(0);
      if (iv && rdy && ird != 5'd0) mq.push_back('{ird, idat, !(pwr && ird == rd)});
      m_blocked = blk ? ((m_blocked < LIM) ? m_blocked + 1 : LIM) : 0;
      m_stall   = (m_blocked == LIM);
   endtask

   task automatic idle();
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   // Asynchronous reset in the middle of a cycle; outputs must clear without waiting for an edge
   task automatic do_reset();
      #1;
      RegWrite_WB = 1'b0;
      ip_valid    = 1'b0;
      rst_n       = 1'b0;
      #1;
      chk("rst_mask",  pending_mask,          32'd0);
      chk("rst_stall", 32'(wb_stall_req),     32'd0);
      chk("rst_ready", 32'(ip_ready),         32'd1);
      chk("rst_we",    32'(rf_we),            32'd0);
      mq.delete();
      m_blocked = 0;
      m_stall   = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int rwp;
      rst_n       = 1'b0;
      RegWrite_WB = 1'b0;
      Rd_WB       = 5'd0;
      Result_WB   = 32'd0;
      ip_valid    = 1'b0;
      ip_rd       = 5'd0;
      ip_data     = 32'd0;
      m_blocked   = 0;
      m_stall     = 1'b0;
      #2;
      chk("init_mask",  pending_mask,      32'd0);
      chk("init_stall", 32'(wb_stall_req), 32'd0);
      chk("init_ready", 32'(ip_ready),     32'd1);
      chk("init_we",    32'(rf_we),        32'd0);
      // The pipeline still owns the port while reset is held
      RegWrite_WB = 1'b1;
      Rd_WB       = 5'd9;
      Result_WB   = 32'h0000_0055;
      #1;
      chk("rst_pipe_we",   32'(rf_we),    32'd1);
      chk("rst_pipe_addr", 32'(rf_waddr), 32'd9);
      chk("rst_pipe_data", rf_wdata,      32'h0000_0055);
      RegWrite_WB = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Idle pipeline: IP result drains the cycle after acceptance
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD_BEEF);
      #1; chk("t1_mask_after_accept", pending_mask, 32'h0000_0020);
      idle();
      #1; chk("t1_mask_after_drain", pending_mask, 32'd0);

      // Pipeline hogs the port: FIFO fills, head starves, then drains on one free cycle
      for (int k = 0; k < 9; k++) begin
         step(1'b1, 5'd3, 32'h3333_0000 + 32'(k), (k < 4), 5'(7 + k), 32'hA000_0000 + 32'(k));
         #1;
         if (k == 3) chk("t2_ready_full", 32'(ip_ready), 32'd0);
         if (k == 7) chk("t2_stall_early", 32'(wb_stall_req), 32'd0);
         if (k == 8) chk("t2_stall_set", 32'(wb_stall_req), 32'd1);
      end
      idle();
      #1;
      chk("t2_stall_clear", 32'(wb_stall_req), 32'd0);
      chk("t2_mask_rest",   pending_mask,      32'h0000_0700);
      idle(); idle(); idle();
      #1; chk("t2_mask_empty", pending_mask, 32'd0);

      // Younger pipeline write kills a buffered entry
      step(1'b1, 5'd3, 32'h1, 1'b1, 5'd12, 32'hC0C0_C0C0);
      #1; chk("t3_mask_held", pending_mask, 32'h0000_1000);
      step(1'b1, 5'd12, 32'h0000_1111, 1'b0, 5'd0, 32'd0);
      #1; chk("t3_mask_killed", pending_mask, 32'd0);
      idle(); idle();

      // Same-cycle accept and pipeline write to the same register
      step(1'b1, 5'd4, 32'h0000_4444, 1'b1, 5'd4, 32'h0000_0BAD);
      #1; chk("t4_mask_dead", pending_mask, 32'd0);
      idle(); idle();

      // r0 on both paths
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h0000_BAD0);
      #1; chk("t5_mask_r0", pending_mask, 32'd0);
      step(1'b1, 5'd0, 32'h0000_0077, 1'b0, 5'd0, 32'd0);
      idle();

      // Mid-stream reset with three entries buffered
      step(1'b1, 5'd3, 32'h1, 1'b1, 5'd20, 32'h14);
      step(1'b1, 5'd3, 32'h2, 1'b1, 5'd21, 32'h15);
      step(1'b1, 5'd3, 32'h3, 1'b1, 5'd22, 32'h16);
      #1; chk("t6_mask_three", pending_mask, 32'h0070_0000);
      do_reset();
      idle(); idle(); idle();

      // Randomized traffic, alternating light and heavy pipeline load over a small register set
      for (int i = 0; i < 1500; i++) begin
         if (i == 700) do_reset();
         rwp = ((i / 250) % 2 == 1) ? 95 : 50;
         step($urandom_range(99) < rwp, 5'($urandom_range(7)), $urandom(),
              $urandom_range(99) < 60, 5'($urandom_range(7)), $urandom());
      end

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
